// File: rtl/serial_adder_unit_if.sv
// serial_adder_unit_if
//   Groups the start/operand/result signals of the bit-serial add/subtract unit.
//   master : requester. Drives start, sub, a, b and cin. Observes busy, done, sum, cout and ovf.
//   slave  : the serial_adder_unit itself.
interface serial_adder_unit_if #(
  parameter int WIDTH = 8
);
  logic             start;  // request to begin an operation
  logic             sub;    // 0 = add, 1 = subtract
  logic [WIDTH-1:0] a;      // operand A
  logic [WIDTH-1:0] b;      // operand B
  logic             cin;    // carry-in for add, ignored for subtract
  logic             busy;   // operation in progress
  logic             done;   // one-cycle result-valid pulse
  logic [WIDTH-1:0] sum;    // registered result
  logic             cout;   // carry out of the MSB (1 = no borrow on subtract)
  logic             ovf;    // signed two's-complement overflow

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder_unit.sv
// serial_adder_unit
//   Bit-serial add/subtract built around one full-adder slice and a carry flop.
//   Operands are processed LSB-first, one bit per clock. After an accepted start,
//   the result appears WIDTH clocks later together with a one-cycle done pulse.
// Ports:
//   clk    : system clock, rising-edge active
//   reset  : asynchronous, active-high reset
//   bus    : serial_adder_unit_if.slave. Carries start/sub/a/b/cin in and
//            busy/done/sum/cout/ovf out.
module serial_adder_unit #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  serial_adder_unit_if.slave  bus
);

  localparam int             CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_PEN  = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic             accept;     // load operands this edge
  logic             step;       // process one bit this edge
  logic             last;       // this edge processes the MSB

  logic [WIDTH-1:0] a_sr, b_sr; // operand shift registers, bit 0 is the current bit
  logic [WIDTH-1:0] ps;         // partial sum. Bits enter at the MSB and migrate down
  logic [CW-1:0]    cnt;        // index of the bit being processed
  logic             c;          // carry flop
  logic             c_msb_in;   // carry into the MSB, used for overflow
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  logic             s_bit, c_nx;

  // Full-adder slice.
  always_comb begin
    s_bit = a_sr[0] ^ b_sr[0] ^ c;
    c_nx  = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    step     = 1'b0;
    last     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        // start is deliberately not looked at here: requests during a run are dropped.
        step = 1'b1;
        if (cnt == CNT_LAST) begin
          last     = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        // Back-to-back: a start in the result cycle launches the next operation.
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments, so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr     <= '0;
      b_sr     <= '0;
      ps       <= '0;
      cnt      <= '0;
      c        <= 1'b0;
      c_msb_in <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      a_sr <= bus.a;
      // Subtract is a + ~b + 1: invert B and seed the carry with 1.
      b_sr <= bus.sub ? ~bus.b : bus.b;
      c    <= bus.sub | bus.cin;
      cnt  <= '0;
      ps   <= '0;
    end else if (step) begin
      a_sr <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr <= {1'b0, b_sr[WIDTH-1:1]};
      ps   <= {s_bit, ps[WIDTH-1:1]};
      c    <= c_nx;
      cnt  <= cnt + 1'b1;
      if (cnt == CNT_PEN) c_msb_in <= c_nx;
      // The visible result only updates once, at the end of the run.
      if (last) begin
        sum_q  <= {s_bit, ps[WIDTH-1:1]};
        cout_q <= c_nx;
        // Signed overflow: carry into the MSB differs from carry out of it.
        ovf_q  <= c_msb_in ^ c_nx;
      end
    end
  end

  // State is registered, so these decodes are clean registered outputs.
  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_unit.sv
// tb_serial_adder_unit
//   Self-checking bench for serial_adder_unit (WIDTH = 8). It covers directed
//   vectors, start ignored mid-run, back-to-back through DONE, reset mid-run,
//   and random operations checked against an integer arithmetic model.
module tb_serial_adder_unit;

  localparam int W = 8;

  logic clk;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  serial_adder_unit_if #(.WIDTH(W)) bus ();

  serial_adder_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model written from the arithmetic rules, using plain integer math.
  function automatic void model(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, output logic [W-1:0] s,
                                output logic co, output logic ov);
    int ua, ub, sa, sb, r, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!sub) begin
      r  = ua + ub + int'(cin);
      sr = sa + sb + int'(cin);
      co = (r > 255);
    end else begin
      r  = ua - ub;
      sr = sa - sb;
      co = (ua >= ub);
    end
    s  = r[W-1:0];
    ov = (sr > 127) || (sr < -128);
  endfunction

  // Called at a negedge. Accepts the operation at the next edge (edge 0).
  task automatic launch(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin);
    bus.start = 1'b1;
    bus.sub   = sub;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    check("done_after_start", 32'(bus.done), 32'd0);
  endtask

  // Walks edges 1..W after a launch. It checks latency, busy and result hold,
  // then returns the outputs seen in the done cycle. A glitch start with other
  // operands can be injected before edge glitch_edge. With chain set, start is
  // raised with chain_a/chain_b and stays high through the DONE cycle.
  task automatic finish_op(input logic [W-1:0] hold_sum, input int glitch_edge,
                           input bit chain, input logic [W-1:0] chain_a,
                           input logic [W-1:0] chain_b,
                           output logic [W-1:0] s, output logic co, output logic ov);
    s  = '0;
    co = 1'b0;
    ov = 1'b0;
    for (int k = 1; k <= W; k++) begin
      if (k == glitch_edge) begin
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h01;
        bus.sub   = ~bus.sub;
      end
      @(posedge clk);
      @(negedge clk);
      if (k == glitch_edge) bus.start = 1'b0;
      if (k < W) begin
        check($sformatf("done_low_e%0d", k), 32'(bus.done), 32'd0);
        check($sformatf("busy_high_e%0d", k), 32'(bus.busy), 32'd1);
        check($sformatf("sum_hold_e%0d", k), 32'(bus.sum), 32'(hold_sum));
        if (chain && k == W - 1) begin
          bus.start = 1'b1;
          bus.sub   = 1'b0;
          bus.a     = chain_a;
          bus.b     = chain_b;
          bus.cin   = 1'b0;
        end
      end else begin
        check("done_at_last_edge", 32'(bus.done), 32'd1);
        check("busy_low_at_last_edge", 32'(bus.busy), 32'd0);
        s  = bus.sum;
        co = bus.cout;
        ov = bus.ovf;
      end
    end
  endtask

  vec_t         vecs [6];
  logic [W-1:0] prev_sum;
  logic [W-1:0] gs, ms;
  logic         gc, go, mc, mo;
  int           done_seen;

  initial begin
    vecs[0] = '{1'b0, 8'h3C, 8'h55, 1'b0, 8'h91, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};

    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum",  32'(bus.sum),  32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_ovf",  32'(bus.ovf),  32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors.
    prev_sum = '0;
    foreach (vecs[i]) begin
      launch(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin);
      finish_op(prev_sum, -1, 1'b0, '0, '0, gs, gc, go);
      check($sformatf("vec%0d_sum", i),  32'(gs), 32'(vecs[i].exp_sum));
      check($sformatf("vec%0d_cout", i), 32'(gc), 32'(vecs[i].exp_cout));
      check($sformatf("vec%0d_ovf", i),  32'(go), 32'(vecs[i].exp_ovf));
      prev_sum = gs;
      @(negedge clk);
      check($sformatf("vec%0d_done_drops", i), 32'(bus.done), 32'd0);
    end

    // Start with different operands at edge 3 of a run is ignored.
    launch(1'b0, 8'h3C, 8'h55, 1'b0);
    finish_op(prev_sum, -1, 1'b0, '0, '0, gs, gc, go);
    check("pre_glitch_sum", 32'(gs), 32'h91);
    @(negedge clk);
    launch(1'b0, 8'h10, 8'h22, 1'b0);
    finish_op(8'h91, 3, 1'b0, '0, '0, gs, gc, go);
    check("glitch_sum",  32'(gs), 32'h32);
    check("glitch_cout", 32'(gc), 32'd0);
    check("glitch_ovf",  32'(go), 32'd0);
    @(negedge clk);
    check("glitch_no_restart", 32'(bus.busy), 32'd0);

    // Back-to-back: start held through the DONE cycle.
    launch(1'b0, 8'h3C, 8'h55, 1'b0);
    finish_op(8'h32, -1, 1'b1, 8'h02, 8'h03, gs, gc, go);
    check("b2b_first_sum", 32'(gs), 32'h91);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_done_drops", 32'(bus.done), 32'd0);
    check("b2b_busy_again", 32'(bus.busy), 32'd1);
    finish_op(8'h91, -1, 1'b0, '0, '0, gs, gc, go);
    check("b2b_second_sum",  32'(gs), 32'h05);
    check("b2b_second_cout", 32'(gc), 32'd0);
    check("b2b_second_ovf",  32'(go), 32'd0);
    @(negedge clk);

    // Reset mid-run: outputs clear at once and no done follows.
    launch(1'b0, 8'h3C, 8'h55, 1'b0);
    finish_op(8'h05, -1, 1'b0, '0, '0, gs, gc, go);
    @(negedge clk);
    launch(1'b0, 8'h7F, 8'h01, 1'b0);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_sum",  32'(bus.sum),  32'd0);
    check("arst_cout", 32'(bus.cout), 32'd0);
    check("arst_ovf",  32'(bus.ovf),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("arst_no_done", 32'(done_seen), 32'd0);
    launch(1'b0, 8'h11, 8'h22, 1'b1);
    finish_op(8'h00, -1, 1'b0, '0, '0, gs, gc, go);
    check("post_rst_sum", 32'(gs), 32'h34);
    prev_sum = gs;
    @(negedge clk);

    // Random operations against the model.
    for (int n = 0; n < 40; n++) begin
      logic         rs, rc;
      logic [W-1:0] ra, rb;
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      ra = W'($urandom);
      rb = W'($urandom);
      model(rs, ra, rb, rc, ms, mc, mo);
      launch(rs, ra, rb, rc);
      finish_op(prev_sum, -1, 1'b0, '0, '0, gs, gc, go);
      check($sformatf("rnd%0d_sum", n),  32'(gs), 32'(ms));
      check($sformatf("rnd%0d_cout", n), 32'(gc), 32'(mc));
      check($sformatf("rnd%0d_ovf", n),  32'(go), 32'(mo));
      prev_sum = gs;
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_adder_unit.md
Name: serial_adder_unit

Overview:
Bit-serial add/subtract unit built around a single full-adder slice and a carry flip-flop. It takes two WIDTH-bit operands and processes them LSB-first, one bit per clock. It then presents a registered sum, carry-out and signed overflow with a start/busy/done handshake. It sits downstream of the combinational adder cells and serves as the low-area arithmetic stage of the project datapath.

Parameters:
WIDTH, 8, operand and result width in bits (must be >= 2)

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
start  input  1  request to begin an operation; sampled on rising clk
sub  input  1  0 = add (a + b + cin), 1 = subtract (a - b)
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in for add; ignored when sub = 1
busy  output  1  high while the operation is in progress
done  output  1  one-cycle pulse: result valid
sum  output  WIDTH  registered result
cout  output  1  carry out of MSB (for subtract, 1 = no borrow)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset: one clock, clk; reset asynchronous active-high.
  - State goes to IDLE; busy = 0, done = 0, sum = 0, cout = 0, ovf = 0.
  - Operand shift registers, carry flop and bit counter are cleared.
  - Reset asserted mid-operation aborts it; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start = 1 at an edge: capture A_sr = a and B_sr = (sub ? ~b : b).
  - Carry flop loads (sub ? 1 : cin); counter loads 0; partial-sum register loads 0.
  - Next state RUN; busy = 1 from this edge.
- RUN, each edge:
  - s = A_sr[0] ^ B_sr[0] ^ c.
  - c_next = majority(A_sr[0], B_sr[0], c).
  - A_sr and B_sr shift right by one.
  - Partial-sum register shifts right with s entering at the MSB.
  - When counter = WIDTH-2, record c_next as c_msb_in (carry into MSB).
  - Counter increments; when counter = WIDTH-1, this is the last bit and the next state is DONE.
- Entering DONE (same edge as the last bit):
  - sum <= final partial-sum value.
  - cout <= c_next.
  - ovf <= c_msb_in ^ c_next.
  - done <= 1; busy <= 0.
- DONE lasts exactly one cycle, then returns to IDLE with done <= 0.
- start in DONE is accepted exactly as in IDLE (back-to-back operation); done still drops on the next edge.
- start during RUN is ignored; operand and sub changes during RUN have no effect.
- Latency: start accepted at edge 0 → bits processed at edges 1..WIDTH → done high from edge WIDTH to edge WIDTH+1.
  - busy is high from edge 0 to edge WIDTH.
- sum, cout and ovf hold their values from the last completed operation until the next DONE entry. They never show partial results.
- Arithmetic is modulo 2^WIDTH. Subtract is a + ~b + 1. ovf is valid for both add and subtract.

Test Plan:
- WIDTH=8; reset, then add 0x3C + 0x55, cin = 0, start at edge 0 → done only at edge 8, sum = 0x91, cout = 0, ovf = 1, busy high for edges 0-8.
- Add 0xFF + 0x01, cin = 0 → sum = 0x00, cout = 1, ovf = 0. Then add 0x7F + 0x00, cin = 1 → sum = 0x80, cout = 0, ovf = 1.
- Subtract 0x10 - 0x20 → sum = 0xF0, cout = 0, ovf = 0. Subtract 0x80 - 0x01 → sum = 0x7F, cout = 1, ovf = 1 (cin = 1 applied, must be ignored).
- After 0x3C + 0x55 completes, pulse start with 0x01 + 0x01 at edge 3 of a new RUN → ignored, that run's result is unchanged; sum holds 0x91 throughout the run.
- start held high through a DONE cycle with new operands 0x02 + 0x03 → second operation begins immediately, done low next edge, second done 8 edges later with sum = 0x05.
- Assert reset at edge 4 of a running operation → busy, done, sum, cout and ovf go to 0 immediately (asynchronously), no done pulse follows, and the next start completes normally.
